square_freq_meter: RTL and testbench

//  Receive-side counterpart of the square-wave audio source. Takes the 16-bit

---
 rtl/square_freq_meter.sv | 167 ++++++++++++++++
 tb/tb_square_freq_meter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_freq_meter.sv
// Squares a 16-bit sample stream with a Schmitt trigger and measures the period and frequency.
// Optional macro FREQ_METER_DUTY_EN adds a high-time counter reported on high_time.
module square_freq_meter #(
    parameter int unsigned HI_THRESH   = 12000,
    parameter int unsigned LO_THRESH   = 8000,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] sample,
    input  logic [31:0] clock_freq,
    output logic [31:0] period,
    output logic [31:0] freq,
    output logic        freq_valid,
    output logic        locked,
    output logic        overrun,
    output logic [31:0] high_time
);

    localparam int unsigned SW = 16;
    localparam int unsigned CW = 32;
    localparam int unsigned BW = 5;
    localparam logic [SW-1:0] HI  = SW'(HI_THRESH);
    localparam logic [SW-1:0] LO  = SW'(LO_THRESH);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    logic          r_level;
    logic          r_rise;
    logic          w_level_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_armed;
    logic          w_timeout;
    logic          w_req;
    state_t        r_state;
    logic [CW-1:0] r_dvd;
    logic [CW-1:0] r_dvs;
    logic [CW-1:0] r_rem;
    logic [BW-1:0] r_bit;
    logic [CW:0]   w_rem_sh;
    logic          w_ge;
    logic [CW-1:0] w_diff;

    // Schmitt trigger: values between the thresholds hold the current level
    always_comb begin
        w_level_nxt = r_level;
        if (sample >= HI) begin
            w_level_nxt = 1'b1;
        end else if (sample <= LO) begin
            w_level_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_rise  <= w_level_nxt & ~r_level;
        end
    end

    // A rise in the same cycle as a saturated count takes priority over timeout
    assign w_timeout = r_armed & ~r_rise & (r_cnt == TMO);
    assign w_req     = r_rise & r_armed;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            period  <= '0;
            locked  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (r_rise) begin
                r_cnt   <= CW'(1);
                r_armed <= 1'b1;
                if (r_armed) begin
                    period  <= r_cnt;
                    locked  <= 1'b1;
                    overrun <= (r_state != S_IDLE);
                end
            end else begin
                if (r_cnt != TMO) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_timeout) begin
                    r_armed <= 1'b0;
                    locked  <= 1'b0;
                end
            end
        end
    end

    // Restoring divider step: remainder stays below the divisor, so the low 32 bits of the difference suffice
    assign w_rem_sh = {r_rem, r_dvd[CW-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_diff   = w_rem_sh[CW-1:0] - r_dvs;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_bit      <= '0;
            freq       <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (w_timeout) begin
                freq       <= '0;
                freq_valid <= 1'b1;
                r_state    <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_req) begin
                            r_dvd   <= clock_freq;
                            r_dvs   <= r_cnt;
                            r_rem   <= '0;
                            r_bit   <= '0;
                            r_state <= S_DIV;
                        end
                    end
                    S_DIV: begin
                        r_rem <= w_ge ? w_diff : w_rem_sh[CW-1:0];
                        r_dvd <= {r_dvd[CW-2:0], w_ge};
                        r_bit <= r_bit + BW'(1);
                        if (r_bit == BW'(CW - 1)) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        freq       <= r_dvd;
                        freq_valid <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef FREQ_METER_DUTY_EN
    logic [CW-1:0] r_high_cnt;

    // Counts level-high cycles from the rise cycle up to the cycle before the next rise
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_high_cnt <= '0;
            high_time  <= '0;
        end else begin
            r_high_cnt <= (r_rise ? CW'(0) : r_high_cnt) + CW'(r_level);
            if (w_req) begin
                high_time <= r_high_cnt;
            end
        end
    end
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_square_freq_meter.sv
// Bench for square_freq_meter: vector table, directed corner sequences and a randomized run
// checked every cycle against an event-level reference model.
module tb_square_freq_meter;

    localparam int T = 2000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] sample = '0;
    logic [31:0] clock_freq = '0;
    logic [31:0] period;
    logic [31:0] freq;
    logic        freq_valid;
    logic        locked;
    logic        overrun;
    logic [31:0] high_time;

    square_freq_meter #(
        .HI_THRESH  (12000),
        .LO_THRESH  (8000),
        .TIMEOUT_CYC(T)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sample    (sample),
        .clock_freq(clock_freq),
        .period    (period),
        .freq      (freq),
        .freq_valid(freq_valid),
        .locked    (locked),
        .overrun   (overrun),
        .high_time (high_time)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int fv_cnt = 0;
    int ov_cnt = 0;
    int last_fv = 0;
    int printed = 0;

    // Reference model state: rise times, divider completion time, expected outputs
    bit          m_level = 0;
    bit          m_rise_pend = 0;
    bit          m_armed = 0;
    bit          m_div_act = 0;
    int          m_last_rise = 0;
    int          m_div_end = 0;
    int          m_hicnt = 0;
    logic [31:0] m_q = '0;
    logic [31:0] e_period = '0;
    logic [31:0] e_freq = '0;
    logic [31:0] e_high = '0;
    logic        e_fv = 0;
    logic        e_lock = 0;
    logic        e_ov = 0;

    function automatic void model_edge(input logic [15:0] s, input logic rn, input logic [31:0] cf);
        bit nl;
        int gap;
        if (!rn) begin
            m_level = 0; m_rise_pend = 0; m_armed = 0; m_div_act = 0; m_hicnt = 0;
            e_period = '0; e_freq = '0; e_high = '0; e_fv = 0; e_lock = 0; e_ov = 0;
            return;
        end
        e_fv = 0;
        e_ov = 0;
        if (m_rise_pend) begin
            if (m_armed) begin
                gap = k - 1 - m_last_rise;
                if (gap > T) gap = T;
                e_period = 32'(gap);
                e_lock = 1;
`ifdef FREQ_METER_DUTY_EN
                e_high = 32'(m_hicnt);
`endif
                if (m_div_act) begin
                    e_ov = 1;
                end else begin
                    m_div_act = 1;
                    m_div_end = k + 33;
                    m_q = cf / 32'(gap);
                end
            end
            m_armed = 1;
            m_last_rise = k - 1;
            m_hicnt = 0;
        end else if (m_armed && (k - 1 - m_last_rise) >= T) begin
            m_armed = 0;
            e_lock = 0;
            e_freq = '0;
            e_fv = 1;
            m_div_act = 0;
        end
        if (m_div_act && k == m_div_end) begin
            e_freq = m_q;
            e_fv = 1;
            m_div_act = 0;
        end
        m_hicnt = m_hicnt + int'(m_level);
        nl = m_level;
        if (s >= 16'd12000) nl = 1;
        else if (s <= 16'd8000) nl = 0;
        m_rise_pend = nl & ~m_level;
        m_level = nl;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] s, input logic rn);
        sample = s;
        reset_n = rn;
        @(posedge clock);
        k++;
        model_edge(s, rn, clock_freq);
        #1;
        checks++;
        if (period !== e_period || freq !== e_freq || freq_valid !== e_fv ||
            locked !== e_lock || overrun !== e_ov || high_time !== e_high) begin
            errors++;
            if (printed < 20) begin
                printed++;
                $display("FAIL cycle %0d actual p=%0d f=%0d v=%b l=%b o=%b h=%0d expected p=%0d f=%0d v=%b l=%b o=%b h=%0d",
                         k, period, freq, freq_valid, locked, overrun, high_time,
                         e_period, e_freq, e_fv, e_lock, e_ov, e_high);
            end
        end
        if (freq_valid === 1'b1) begin fv_cnt++; last_fv = k; end
        if (overrun === 1'b1) ov_cnt++;
    endtask

    task automatic hold(input logic [15:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b1);
    endtask

    task automatic do_reset();
        step(16'd20000, 1'b0);
        step(16'd0, 1'b0);
    endtask

    function automatic logic [15:0] hi_val();
        return 16'($urandom_range(65535, 12000));
    endfunction

    function automatic logic [15:0] lo_val();
        return 16'($urandom_range(8000, 0));
    endfunction

    typedef struct {
        int          hi;
        int          lo;
        logic [31:0] cf;
        logic [31:0] e_per;
        logic [31:0] e_freq;
        logic [31:0] e_high;
    } vec_t;

    initial begin
        vec_t        tbl[8];
        logic [31:0] exp_h;
        int          ca, cb, cr, hl, ll;

        tbl[0] = '{501, 501, 32'd1000000, 32'd1002, 32'd998, 32'd501};
        tbl[1] = '{300, 700, 32'd50000000, 32'd1000, 32'd50000, 32'd300};
        tbl[2] = '{17, 20, 32'd1000, 32'd37, 32'd27, 32'd17};
        tbl[3] = '{40, 60, 32'd48000, 32'd100, 32'd480, 32'd40};
        tbl[4] = '{1, 33, 32'd3400, 32'd34, 32'd100, 32'd1};
        tbl[5] = '{1000, 999, 32'd12345678, 32'd1999, 32'd6175, 32'd1000};
        tbl[6] = '{20, 20, 32'hFFFFFFFF, 32'd40, 32'd107374182, 32'd20};
        tbl[7] = '{1, 1999, 32'd2000000, 32'd2000, 32'd1000, 32'd1};

        // Reset with the input toggling
        clock_freq = 32'd1000000;
        do_reset();
        check("rst_period", period, 32'd0);
        check("rst_freq", freq, 32'd0);
        check("rst_valid", 32'(freq_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_high", high_time, 32'd0);

        // Vector table: steady squares
        foreach (tbl[i]) begin
            clock_freq = tbl[i].cf;
            do_reset();
            for (int p = 0; p < 3; p++) begin
                for (int j = 0; j < tbl[i].lo; j++) step(lo_val(), 1'b1);
                for (int j = 0; j < tbl[i].hi; j++) step(hi_val(), 1'b1);
            end
            hold(16'd0, 60);
`ifdef FREQ_METER_DUTY_EN
            exp_h = tbl[i].e_high;
`else
            exp_h = 32'd0;
`endif
            check($sformatf("vec%0d_period", i), period, tbl[i].e_per);
            check($sformatf("vec%0d_freq", i), freq, tbl[i].e_freq);
            check($sformatf("vec%0d_high", i), high_time, exp_h);
            check($sformatf("vec%0d_locked", i), 32'(locked), 32'd1);
        end

        // Jitter inside the hysteresis band gives a single crossing
        clock_freq = 32'd1000000;
        do_reset();
        hold(16'd0, 50);
        step(16'd20000, 1'b1);
        ca = k;
        hold(16'd20000, 30);
        hold(16'd0, 100);
        for (int j = 0; j < 30; j++) step(16'($urandom_range(11999, 8001)), 1'b1);
        fv_cnt = 0;
        ov_cnt = 0;
        step(16'd13000, 1'b1);
        cb = k;
        for (int j = 0; j < 60; j++) step(16'($urandom_range(13000, 8001)), 1'b1);
        step(16'd7000, 1'b1);
        for (int j = 0; j < 60; j++) step(16'($urandom_range(11999, 7000)), 1'b1);
        check("jitter_valid_count", 32'(fv_cnt), 32'd1);
        check("jitter_overrun_count", 32'(ov_cnt), 32'd0);
        check("jitter_period", period, 32'(cb - ca));

        // Timeout after the last rise
        clock_freq = 32'd600000;
        do_reset();
        cr = 0;
        for (int p = 0; p < 3; p++) begin
            hold(16'd0, 30);
            step(16'd20000, 1'b1);
            cr = k;
            hold(16'd20000, 29);
        end
        fv_cnt = 0;
        hold(16'd0, T + 100);
        check("tmo_valid_count", 32'(fv_cnt), 32'd2);
        check("tmo_valid_cycle", 32'(last_fv), 32'(cr + T + 1));
        check("tmo_locked", 32'(locked), 32'd0);
        check("tmo_freq", freq, 32'd0);
        check("tmo_period", period, 32'd60);

        // Period 20: every other rise lands mid-divide
        clock_freq = 32'd1000000;
        do_reset();
        hold(16'd0, 10);
        fv_cnt = 0;
        ov_cnt = 0;
        for (int p = 0; p < 9; p++) begin
            hold(16'd20000, 10);
            hold(16'd0, 10);
        end
        hold(16'd0, 50);
        check("short_overrun_count", 32'(ov_cnt), 32'd4);
        check("short_valid_count", 32'(fv_cnt), 32'd4);
        check("short_period", period, 32'd20);
        check("short_freq", freq, 32'd50000);

        // Reset in the middle of a divide
        clock_freq = 32'd600000;
        do_reset();
        hold(16'd0, 40);
        hold(16'd20000, 40);
        hold(16'd0, 40);
        hold(16'd20000, 10);
        fv_cnt = 0;
        step(16'd20000, 1'b0);
        step(16'd20000, 1'b0);
        hold(16'd20000, 20);
        hold(16'd0, 40);
        check("rstdiv_valid_count", 32'(fv_cnt), 32'd0);
        check("rstdiv_period", period, 32'd0);
        check("rstdiv_locked", 32'(locked), 32'd0);
        hold(16'd20000, 40);
        check("rstdiv_period2", period, 32'd60);
        check("rstdiv_freq2", freq, 32'd10000);
        check("rstdiv_locked2", 32'(locked), 32'd1);

        // Randomized segments against the reference model
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            clock_freq = $urandom;
            hl = int'($urandom_range(70, 1));
            if ($urandom_range(9, 0) == 0) ll = T - 2 - hl + int'($urandom_range(6, 0));
            else ll = int'($urandom_range(70, 1));
            if (ll < 1) ll = 1;
            step(hi_val(), 1'b1);
            for (int j = 1; j < hl; j++) step(16'($urandom_range(65535, 8001)), 1'b1);
            step(lo_val(), 1'b1);
            for (int j = 1; j < ll; j++) step(16'($urandom_range(11999, 0)), 1'b1);
        end
        hold(16'd0, T + 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
